pic_fetch_decode: RTL and testbench

Instruction fetch/decode sequencer for the PIC10F20x core. Owns the program counter, 2-level return stack and program-ROM address. Decodes each 12-bit instruction word into the ALU's command interface (`alu_instruction`, `bit_num`, `literal_value`, `dest_bit`) plus a file-register address. Consumes the ALU's `skip` to squash the following instruction, and executes GOTO/CALL/RETLW itself.

---
 rtl/pic_fetch_decode_pkg.sv | 93 +++++++++
 rtl/pic_inst_decode.sv | 85 ++++++++
 rtl/pic_fetch_decode.sv | 114 +++++++++++
 tb/tb_pic_fetch_decode.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_fetch_decode_pkg.sv
// Shared constants and types for the PIC10F20x fetch/decode sequencer:
// ALU command codes, misc-op codes, branch kinds and the decoded-word record.
package pic_fetch_decode_pkg;

  localparam int PC_WIDTH       = 9;
  localparam int IWIDTH         = 12;
  localparam int DWIDTH         = 8;
  localparam int L2_DWIDTH      = 3;
  localparam int ALU_INST_WIDTH = 5;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 9'h1FF;

  typedef logic [ALU_INST_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_ADDWF  = 5'd0;
  localparam alu_op_t ALU_ANDWF  = 5'd1;
  localparam alu_op_t ALU_CLRF   = 5'd2;
  localparam alu_op_t ALU_CLRW   = 5'd3;
  localparam alu_op_t ALU_COMF   = 5'd4;
  localparam alu_op_t ALU_DECF   = 5'd5;
  localparam alu_op_t ALU_DECFSZ = 5'd6;
  localparam alu_op_t ALU_INCF   = 5'd7;
  localparam alu_op_t ALU_INCFSZ = 5'd8;
  localparam alu_op_t ALU_IORWF  = 5'd9;
  localparam alu_op_t ALU_MOVF   = 5'd10;
  localparam alu_op_t ALU_MOVWF  = 5'd11;
  localparam alu_op_t ALU_RLF    = 5'd12;
  localparam alu_op_t ALU_RRF    = 5'd13;
  localparam alu_op_t ALU_SUBWF  = 5'd14;
  localparam alu_op_t ALU_SWAPF  = 5'd15;
  localparam alu_op_t ALU_XORWF  = 5'd16;
  localparam alu_op_t ALU_BCF    = 5'd17;
  localparam alu_op_t ALU_BSF    = 5'd18;
  localparam alu_op_t ALU_BTFSC  = 5'd19;
  localparam alu_op_t ALU_BTFSS  = 5'd20;
  localparam alu_op_t ALU_ANDLW  = 5'd21;
  localparam alu_op_t ALU_IORLW  = 5'd22;
  localparam alu_op_t ALU_MOVLW  = 5'd23;
  localparam alu_op_t ALU_XORLW  = 5'd24;
  localparam alu_op_t ALU_NOP    = 5'd31;

  localparam logic [1:0] MISC_OPTION = 2'd0;
  localparam logic [1:0] MISC_TRIS   = 2'd1;
  localparam logic [1:0] MISC_SLEEP  = 2'd2;
  localparam logic [1:0] MISC_CLRWDT = 2'd3;

  typedef enum logic [1:0] {
    BR_NONE  = 2'd0,
    BR_GOTO  = 2'd1,
    BR_CALL  = 2'd2,
    BR_RETLW = 2'd3
  } branch_t;

  typedef struct packed {
    alu_op_t               alu;
    logic [L2_DWIDTH-1:0]  bit_num;
    logic [DWIDTH-1:0]     literal_value;
    logic                  dest_bit;
    logic [4:0]            freg_addr;
    branch_t               branch;
    logic [PC_WIDTH-1:0]   target;
    logic                  misc_valid;
    logic [1:0]            misc_op;
  } decode_t;

  localparam decode_t DECODE_NOP = '{
    alu: ALU_NOP, bit_num: 3'd0, literal_value: 8'd0, dest_bit: 1'b0,
    freg_addr: 5'd0, branch: BR_NONE, target: 9'd0, misc_valid: 1'b0,
    misc_op: 2'd0
  };

  // Byte-oriented file ops are selected by instr[9:6] (0000/0001 are not d-type).
  function automatic alu_op_t file_op(input logic [3:0] sel);
    case (sel)
      4'b0010: return ALU_SUBWF;
      4'b0011: return ALU_DECF;
      4'b0100: return ALU_IORWF;
      4'b0101: return ALU_ANDWF;
      4'b0110: return ALU_XORWF;
      4'b0111: return ALU_ADDWF;
      4'b1000: return ALU_MOVF;
      4'b1001: return ALU_COMF;
      4'b1010: return ALU_INCF;
      4'b1011: return ALU_DECFSZ;
      4'b1100: return ALU_RRF;
      4'b1101: return ALU_RLF;
      4'b1110: return ALU_SWAPF;
      4'b1111: return ALU_INCFSZ;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/pic_inst_decode.sv
// Combinational decode of one 12-bit PIC10F20x instruction word into ALU
// command fields, branch kind/target and misc (OPTION/TRIS/SLEEP/CLRWDT) op.
module pic_inst_decode
  import pic_fetch_decode_pkg::*;
(
  input  logic [IWIDTH-1:0] instr,
  output decode_t           dec
);

  // Map the word onto its opcode group; anything unlisted decodes as NOP
  always_comb begin
    dec = DECODE_NOP;
    casez (instr)
      12'b0000_0000_0010: begin
        dec.misc_valid = 1'b1;
        dec.misc_op    = MISC_OPTION;
      end
      12'b0000_0000_0011: begin
        dec.misc_valid = 1'b1;
        dec.misc_op    = MISC_SLEEP;
      end
      12'b0000_0000_0100: begin
        dec.misc_valid = 1'b1;
        dec.misc_op    = MISC_CLRWDT;
      end
      12'b0000_0000_011?: begin
        dec.misc_valid = 1'b1;
        dec.misc_op    = MISC_TRIS;
        dec.freg_addr  = instr[4:0];
      end
      12'b0000_0100_0000: begin
        dec.alu = ALU_CLRW;
      end
      12'b0000_001?_????: begin
        dec.alu       = ALU_MOVWF;
        dec.freg_addr = instr[4:0];
      end
      12'b0000_011?_????: begin
        dec.alu       = ALU_CLRF;
        dec.freg_addr = instr[4:0];
      end
      12'b0000_1???_????, 12'b0001_????_????, 12'b001?_????_????: begin
        dec.alu       = file_op(instr[9:6]);
        dec.dest_bit  = instr[5];
        dec.freg_addr = instr[4:0];
      end
      12'b01??_????_????: begin
        case (instr[9:8])
          2'b00:   dec.alu = ALU_BCF;
          2'b01:   dec.alu = ALU_BSF;
          2'b10:   dec.alu = ALU_BTFSC;
          2'b11:   dec.alu = ALU_BTFSS;
          default: dec.alu = ALU_NOP;
        endcase
        dec.bit_num   = instr[7:5];
        dec.freg_addr = instr[4:0];
      end
      12'b1000_????_????: begin
        dec.alu           = ALU_MOVLW;
        dec.literal_value = instr[7:0];
        dec.branch        = BR_RETLW;
      end
      12'b1001_????_????: begin
        dec.branch = BR_CALL;
        dec.target = {1'b0, instr[7:0]};
      end
      12'b101?_????_????: begin
        dec.branch = BR_GOTO;
        dec.target = instr[8:0];
      end
      12'b11??_????_????: begin
        case (instr[9:8])
          2'b00:   dec.alu = ALU_MOVLW;
          2'b01:   dec.alu = ALU_IORLW;
          2'b10:   dec.alu = ALU_ANDLW;
          2'b11:   dec.alu = ALU_XORLW;
          default: dec.alu = ALU_NOP;
        endcase
        dec.literal_value = instr[7:0];
      end
      default: dec = DECODE_NOP;
    endcase
  end

endmodule

// File: rtl/pic_fetch_decode.sv
// Fetch/decode sequencer: owns the PC, 2-deep return stack and the E-stage
// register that drives the ALU command interface; executes GOTO/CALL/RETLW.
module pic_fetch_decode
  import pic_fetch_decode_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PC_WIDTH-1:0]       prog_addr,
  input  logic [IWIDTH-1:0]         prog_data,
  input  logic                      skip,
  output logic [ALU_INST_WIDTH-1:0] alu_instruction,
  output logic [L2_DWIDTH-1:0]      bit_num,
  output logic [DWIDTH-1:0]         literal_value,
  output logic                      dest_bit,
  output logic [4:0]                freg_addr,
  output logic [1:0]                misc_op,
  output logic                      misc_valid
);

  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] d_pc_r;
  logic [PC_WIDTH-1:0] e_pc_r;
  logic [PC_WIDTH-1:0] stack0_r;
  logic [PC_WIDTH-1:0] stack1_r;
  logic                f_valid_r;
  logic                e_valid_r;
  decode_t             dec_s;
  decode_t             e_r;
  logic                take_branch_s;

  pic_inst_decode u_decode (
    .instr (prog_data),
    .dec   (dec_s)
  );

  // A branch in E redirects only when its slot is live and not squashed
  always_comb begin
    if (e_valid_r && !skip && (e_r.branch != BR_NONE)) begin
      take_branch_s = 1'b1;
    end else begin
      take_branch_s = 1'b0;
    end
  end

  // PC, return stack and fetch-valid tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_VECTOR;
      d_pc_r    <= 9'd0;
      f_valid_r <= 1'b0;
      stack0_r  <= 9'd0;
      stack1_r  <= 9'd0;
    end else begin
      d_pc_r    <= pc_r;
      // the word arriving next cycle is wrong-path after a redirect
      f_valid_r <= !take_branch_s;
      if (take_branch_s) begin
        case (e_r.branch)
          BR_GOTO: pc_r <= e_r.target;
          BR_CALL: begin
            pc_r     <= e_r.target;
            stack0_r <= e_pc_r + 9'd1;
            stack1_r <= stack0_r;
          end
          BR_RETLW: begin
            pc_r     <= stack0_r;
            stack0_r <= stack1_r;
          end
          default: pc_r <= pc_r + 9'd1;
        endcase
      end else begin
        pc_r <= pc_r + 9'd1;
      end
    end
  end

  // D -> E register; invalid or flushed slots load an all-NOP record
  always_ff @(posedge clk) begin
    if (rst) begin
      e_r       <= DECODE_NOP;
      e_valid_r <= 1'b0;
      e_pc_r    <= 9'd0;
    end else if (f_valid_r && !take_branch_s) begin
      e_r       <= dec_s;
      e_valid_r <= 1'b1;
      e_pc_r    <= d_pc_r;
    end else begin
      e_r       <= DECODE_NOP;
      e_valid_r <= 1'b0;
      e_pc_r    <= d_pc_r;
    end
  end

  // Squash acts within the same cycle on the slot currently in E
  always_comb begin
    if (skip) begin
      alu_instruction = ALU_NOP;
      misc_valid      = 1'b0;
    end else begin
      alu_instruction = e_r.alu;
      misc_valid      = e_r.misc_valid;
    end
  end

  assign prog_addr     = pc_r;
  assign bit_num       = e_r.bit_num;
  assign literal_value = e_r.literal_value;
  assign dest_bit      = e_r.dest_bit;
  assign freg_addr     = e_r.freg_addr;
  assign misc_op       = e_r.misc_op;

endmodule

// File: tb/tb_pic_fetch_decode.sv
// Bench for pic_fetch_decode: a hand-annotated ROM image drives an
// instruction-level model (execute address, bubble count, return stack).
module tb_pic_fetch_decode;
  import pic_fetch_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        skip;
  logic [8:0]  prog_addr;
  logic [11:0] prog_data;
  logic [4:0]  alu_instruction;
  logic [2:0]  bit_num;
  logic [7:0]  literal_value;
  logic        dest_bit;
  logic [4:0]  freg_addr;
  logic [1:0]  misc_op;
  logic        misc_valid;

  pic_fetch_decode dut (
    .clk             (clk),
    .rst             (rst),
    .prog_addr       (prog_addr),
    .prog_data       (prog_data),
    .skip            (skip),
    .alu_instruction (alu_instruction),
    .bit_num         (bit_num),
    .literal_value   (literal_value),
    .dest_bit        (dest_bit),
    .freg_addr       (freg_addr),
    .misc_op         (misc_op),
    .misc_valid      (misc_valid)
  );

  always #5 clk = ~clk;

  localparam int K_NONE = 0;
  localparam int K_GOTO = 1;
  localparam int K_CALL = 2;
  localparam int K_RET  = 3;

  // ROM image plus the hand-written expectation for each word
  logic [11:0] rom_word [512];
  logic [4:0]  x_alu    [512];
  logic [2:0]  x_bit    [512];
  logic [7:0]  x_lit    [512];
  logic        x_dest   [512];
  logic [4:0]  x_freg   [512];
  logic        x_mv     [512];
  logic [1:0]  x_mop    [512];
  int          x_kind   [512];
  logic [8:0]  x_tgt    [512];
  logic        skip_at  [512];

  always @(posedge clk) prog_data <= rom_word[prog_addr];

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] m_exec;
  logic [8:0] m_stack0;
  logic [8:0] m_stack1;
  int         m_bubbles;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) begin
      rom_word[i] = 12'h000; x_alu[i] = ALU_NOP; x_bit[i] = 3'd0; x_lit[i] = 8'd0;
      x_dest[i] = 1'b0; x_freg[i] = 5'd0; x_mv[i] = 1'b0; x_mop[i] = 2'd0;
      x_kind[i] = K_NONE; x_tgt[i] = 9'd0; skip_at[i] = 1'b0;
    end
  endtask

  task automatic put_op(input int a, input logic [11:0] w, input logic [4:0] alu,
                        input logic [2:0] b, input logic [7:0] l, input logic d,
                        input logic [4:0] f);
    rom_word[a] = w; x_alu[a] = alu; x_bit[a] = b; x_lit[a] = l; x_dest[a] = d; x_freg[a] = f;
  endtask

  task automatic put_misc(input int a, input logic [11:0] w, input logic [1:0] mop,
                          input logic [4:0] f);
    rom_word[a] = w; x_mv[a] = 1'b1; x_mop[a] = mop; x_freg[a] = f;
  endtask

  task automatic put_br(input int a, input logic [11:0] w, input int kind,
                        input logic [8:0] tgt, input logic [7:0] l);
    rom_word[a] = w; x_kind[a] = kind; x_tgt[a] = tgt;
    if (kind == K_RET) begin
      x_alu[a] = ALU_MOVLW; x_lit[a] = l;
    end
  endtask

  task automatic model_reset();
    m_exec = 9'h1FF; m_stack0 = 9'd0; m_stack1 = 9'd0; m_bubbles = 2;
  endtask

  task automatic reset_check();
    check("rst_prog_addr", int'(prog_addr), 32'h1FF);
    check("rst_alu", int'(alu_instruction), int'(ALU_NOP));
    check("rst_bit_num", int'(bit_num), 0);
    check("rst_literal", int'(literal_value), 0);
    check("rst_dest", int'(dest_bit), 0);
    check("rst_freg", int'(freg_addr), 0);
    check("rst_misc_valid", int'(misc_valid), 0);
    check("rst_misc_op", int'(misc_op), 0);
  endtask

  // One iteration per clock: drive skip, compare against the model, advance it
  task automatic run_phase(input int phase, input int n);
    logic [8:0] exp_pa;
    logic [8:0] tgt;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      skip = (m_bubbles == 0) && skip_at[m_exec];
      #1;
      exp_pa = m_exec + 9'd2 - 9'(m_bubbles);
      check("prog_addr", int'(prog_addr), int'(exp_pa));
      if (m_bubbles > 0) begin
        check("bubble_alu", int'(alu_instruction), int'(ALU_NOP));
        check("bubble_misc_valid", int'(misc_valid), 0);
        check("bubble_literal", int'(literal_value), 0);
        check("bubble_freg", int'(freg_addr), 0);
      end else begin
        check("alu", int'(alu_instruction), skip ? int'(ALU_NOP) : int'(x_alu[m_exec]));
        check("misc_valid", int'(misc_valid), skip ? 0 : int'(x_mv[m_exec]));
        if (!skip) begin
          check("bit_num", int'(bit_num), int'(x_bit[m_exec]));
          check("literal", int'(literal_value), int'(x_lit[m_exec]));
          check("dest_bit", int'(dest_bit), int'(x_dest[m_exec]));
          check("freg_addr", int'(freg_addr), int'(x_freg[m_exec]));
          check("misc_op", int'(misc_op), int'(x_mop[m_exec]));
        end
      end
      // literal anchors, hand-counted from the programs below
      if (phase == 1) begin
        case (c)
          0:  check("pin_reset_vector", int'(prog_addr), 32'h1FF);
          1:  check("pin_wrap_to_0", int'(prog_addr), 32'h000);
          2:  begin
                check("pin_calib_movlw", int'(alu_instruction), int'(ALU_MOVLW));
                check("pin_calib_lit", int'(literal_value), 32'h25);
              end
          7:  check("pin_skipped_movlw", int'(alu_instruction), int'(ALU_NOP));
          16: check("pin_goto_target", int'(prog_addr), 32'h0A5);
          20: check("pin_skipped_goto_seq", int'(prog_addr), 32'h0A9);
          27: begin
                check("pin_retlw_alu", int'(alu_instruction), int'(ALU_MOVLW));
                check("pin_retlw_lit", int'(literal_value), 32'h55);
              end
          28: check("pin_return_addr", int'(prog_addr), 32'h011);
          46: check("pin_overflow_return", int'(prog_addr), 32'h031);
          default: ;
        endcase
      end else begin
        case (c)
          2:  check("pin_p2_lit", int'(literal_value), 32'hA0);
          14: check("pin_p2_ret1", int'(prog_addr), 32'h008);
          17: check("pin_p2_ret2", int'(prog_addr), 32'h000);
          default: ;
        endcase
      end
      if (m_bubbles > 0) begin
        m_bubbles--;
      end else if (skip) begin
        m_exec = m_exec + 9'd1;
      end else begin
        tgt = x_tgt[m_exec];
        case (x_kind[m_exec])
          K_GOTO: begin m_exec = tgt; m_bubbles = 2; end
          K_CALL: begin
            m_stack1 = m_stack0; m_stack0 = m_exec + 9'd1; m_exec = tgt; m_bubbles = 2;
          end
          K_RET: begin m_exec = m_stack0; m_stack0 = m_stack1; m_bubbles = 2; end
          default: m_exec = m_exec + 9'd1;
        endcase
      end
      @(negedge clk);
    end
  endtask

  task automatic load_phase1();
    clear_rom();
    put_op(9'h1FF, 12'hC25, ALU_MOVLW, 3'd0, 8'h25, 1'b0, 5'd0);
    put_op(9'h001, 12'h1E7, ALU_ADDWF, 3'd0, 8'h00, 1'b1, 5'd7);
    put_op(9'h002, 12'h5A6, ALU_BSF, 3'd5, 8'h00, 1'b0, 5'd6);
    put_op(9'h003, 12'h2C8, ALU_DECFSZ, 3'd0, 8'h00, 1'b0, 5'd8);
    put_op(9'h004, 12'hC11, ALU_MOVLW, 3'd0, 8'h11, 1'b0, 5'd0);
    skip_at[9'h004] = 1'b1;
    put_op(9'h005, 12'h0A1, ALU_SUBWF, 3'd0, 8'h00, 1'b1, 5'd1);
    put_misc(9'h006, 12'h002, MISC_OPTION, 5'd0);
    put_misc(9'h007, 12'h006, MISC_TRIS, 5'd6);
    put_misc(9'h008, 12'h003, MISC_SLEEP, 5'd0);
    put_misc(9'h009, 12'h004, MISC_CLRWDT, 5'd0);
    put_op(9'h00A, 12'h026, ALU_MOVWF, 3'd0, 8'h00, 1'b0, 5'd6);
    put_op(9'h00B, 12'hE0F, ALU_ANDLW, 3'd0, 8'h0F, 1'b0, 5'd0);
    put_br(9'h00C, 12'hAA5, K_GOTO, 9'h0A5, 8'h00);
    put_op(9'h00D, 12'hC77, ALU_MOVLW, 3'd0, 8'h77, 1'b0, 5'd0);
    put_op(9'h00E, 12'hC77, ALU_MOVLW, 3'd0, 8'h77, 1'b0, 5'd0);
    put_op(9'h0A5, 12'h7E3, ALU_BTFSS, 3'd7, 8'h00, 1'b0, 5'd3);
    put_br(9'h0A6, 12'hA10, K_GOTO, 9'h010, 8'h00);
    skip_at[9'h0A6] = 1'b1;
    put_op(9'h0A7, 12'hD3C, ALU_IORLW, 3'd0, 8'h3C, 1'b0, 5'd0);
    put_br(9'h0A8, 12'hA10, K_GOTO, 9'h010, 8'h00);
    put_br(9'h010, 12'h940, K_CALL, 9'h040, 8'h00);
    put_br(9'h040, 12'h855, K_RET, 9'h000, 8'h55);
    put_br(9'h011, 12'h930, K_CALL, 9'h030, 8'h00);
    put_br(9'h030, 12'h950, K_CALL, 9'h050, 8'h00);
    put_br(9'h050, 12'h960, K_CALL, 9'h060, 8'h00);
    put_br(9'h060, 12'h866, K_RET, 9'h000, 8'h66);
    put_br(9'h051, 12'h877, K_RET, 9'h000, 8'h77);
    put_br(9'h031, 12'h888, K_RET, 9'h000, 8'h88);
  endtask

  task automatic load_phase2();
    clear_rom();
    put_op(9'h1FF, 12'hCA0, ALU_MOVLW, 3'd0, 8'hA0, 1'b0, 5'd0);
    put_op(9'h000, 12'hFFF, ALU_XORLW, 3'd0, 8'hFF, 1'b0, 5'd0);
    put_op(9'h001, 12'h3FF, ALU_INCFSZ, 3'd0, 8'h00, 1'b1, 5'd31);
    put_op(9'h002, 12'h4E1, ALU_BCF, 3'd7, 8'h00, 1'b0, 5'd1);
    put_op(9'h003, 12'h605, ALU_BTFSC, 3'd0, 8'h00, 1'b0, 5'd5);
    put_op(9'h004, 12'h040, ALU_CLRW, 3'd0, 8'h00, 1'b0, 5'd0);
    put_op(9'h005, 12'h07F, ALU_CLRF, 3'd0, 8'h00, 1'b0, 5'd31);
    put_br(9'h006, 12'h920, K_CALL, 9'h020, 8'h00);
    skip_at[9'h006] = 1'b1;
    put_br(9'h007, 12'h921, K_CALL, 9'h021, 8'h00);
    put_br(9'h021, 12'h85A, K_RET, 9'h000, 8'h5A);
    put_br(9'h008, 12'h83C, K_RET, 9'h000, 8'h3C);
  endtask

  initial begin
    rst  = 1'b1;
    skip = 1'b0;
    load_phase1();
    repeat (2) @(negedge clk);
    reset_check();
    rst = 1'b0;
    model_reset();
    run_phase(1, 60);

    // reset while CALL/RETLW traffic is in flight
    rst  = 1'b1;
    skip = 1'b0;
    @(negedge clk);
    cyc = 0;
    reset_check();
    load_phase2();
    rst = 1'b0;
    model_reset();
    run_phase(2, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
